// File: rtl/lsu_mem_ctrl.sv
// Purpose : data-side load/store initiator for the unified word-addressed memory; builds
//           byte/half accesses from word cycles (extract+extend on loads, read-modify-write on SB/SH).
// Latency : accept->done: load 2, SW 2, SB/SH 3, error 1 cycle; one request at a time, req ignored while busy.
// Ports   : clk/rst_n; request side req/is_store/funct3/addr/wdata -> busy/done/err/rdata;
//           memory side mem_sel/mem_addr/mem_we/mem_wd driven out, mem_rd read back combinationally.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        err_q;

  // Request screening, evaluated on the raw inputs while IDLE.
  logic f3_ok;
  logic misaligned;
  logic out_of_range;
  logic req_err;

  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !is_store;  // unsigned widths only exist for loads
      default:                f3_ok = 1'b0;
    endcase
    misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr >= 32'(MEM_BYTES));
    req_err      = !f3_ok || misaligned || out_of_range;
  end

  // Little-endian extraction of the loaded word straight from mem_rd, so rdata
  // can be written on the RD->DONE edge without an extra cycle.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rd[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = mem_rd;
    endcase
  end

  // Store data merge: sub-word stores patch the lane into the word read in RD.
  logic [31:0] st_val;

  always_comb begin
    st_val = word_q;
    case (funct3_q[1:0])
      2'b00:   st_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   st_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_val = wdata_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      word_q     <= 32'h0;
      err_q      <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_q     <= addr;
            wdata_q    <= wdata;
            err_q      <= req_err;
            if (req_err)
              state <= DONE;
            else if (is_store && (funct3[1:0] == 2'b10))
              state <= WR;   // full-word store needs no read
            else
              state <= RD;
          end
        end
        RD: begin
          word_q <= mem_rd;
          if (is_store_q) begin
            state <= WR;
          end else begin
            rdata <= ld_val;
            state <= DONE;
          end
        end
        WR:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of the state register: an asynchronous reset
  // drops mem_we immediately, so an interrupted RMW never writes.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = (state == DONE) && err_q;
    mem_sel  = (state == RD) || (state == WR);
    mem_we   = (state == WR);
    mem_addr = mem_sel ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wd   = mem_we ? st_val : 32'h0;
  end

endmodule
